expansion_mix_pipe: RTL and testbench

- Parametrised, pipelined successor to the fixed 32->48 DES expansion permutation.
- Generalises the E-box to any width/group size, optionally XORs a round key, and carries a sideband tag.
- Registers the result through PIPE stages with valid/ready backpressure.
- Sits in the Feistel round datapath between the right-half register and the S-box stage.

---
 rtl/expansion_mix_pipe.sv | 90 +++++++++
 tb/tb_expansion_mix_pipe.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/expansion_mix_pipe.sv
// Parametrised DES-style E-box expansion with optional round-key XOR,
// registered through PIPE valid/ready stages with a sideband tag.
module expansion_mix_pipe #(
   parameter int IN_W  = 32,
   parameter int GRP   = 4,
   parameter int PIPE  = 2,
   parameter int TAG_W = 4,
   localparam int OUT_W = (IN_W / GRP) * (GRP + 2)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_data,
   input  logic [OUT_W-1:0] in_key,
   input  logic             in_mode,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data,
   output logic [TAG_W-1:0] out_tag
);

   localparam int NG = IN_W / GRP;

   if ((IN_W % GRP) != 0 || PIPE < 1) begin : g_bad_cfg
      $fatal(1, "expansion_mix_pipe: IN_W must be a multiple of GRP and PIPE >= 1");
   end

   logic [OUT_W-1:0] w_exp;
   logic [OUT_W-1:0] w_mix;
   logic [PIPE-1:0]  w_load;

   logic             r_vld  [PIPE];
   logic [OUT_W-1:0] r_data [PIPE];
   logic [TAG_W-1:0] r_tag  [PIPE];

   // Each group takes its GRP bits plus one neighbour on each side, wrapping
   for (genvar g = 0; g < NG; g++) begin : g_grp
      for (genvar k = 0; k < GRP + 2; k++) begin : g_bit
         assign w_exp[g*(GRP+2)+k] = in_data[(g*GRP + k - 1 + IN_W) % IN_W];
      end
   end

   assign w_mix = in_mode ? w_exp : (w_exp ^ in_key);

   // A stage loads if empty or if everything downstream makes room this cycle
   always_comb begin
      logic w_t;
      w_load = '0;
      w_t    = out_ready;
      for (int i = PIPE - 1; i >= 0; i--) begin
         w_t       = !r_vld[i] || w_t;
         w_load[i] = w_t;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < PIPE; i++) begin
            r_vld[i]  <= 1'b0;
            r_data[i] <= '0;
            r_tag[i]  <= '0;
         end
      end else begin
         if (w_load[0]) begin
            r_vld[0] <= in_valid;
            if (in_valid) begin
               r_data[0] <= w_mix;
               r_tag[0]  <= in_tag;
            end
         end
         for (int i = 1; i < PIPE; i++) begin
            if (w_load[i]) begin
               r_vld[i] <= r_vld[i-1];
               if (r_vld[i-1]) begin
                  r_data[i] <= r_data[i-1];
                  r_tag[i]  <= r_tag[i-1];
               end
            end
         end
      end
   end

   assign in_ready  = w_load[0];
   assign out_valid = r_vld[PIPE-1];
   assign out_data  = r_data[PIPE-1];
   assign out_tag   = r_tag[PIPE-1];

endmodule

// File: tb/tb_expansion_mix_pipe.sv
// Directed and randomized checks of expansion_mix_pipe against a
// table-rule reference model and a FIFO scoreboard.
module tb_expansion_mix_pipe;

   localparam int IN_W  = 32;
   localparam int GRP   = 4;
   localparam int PIPE  = 2;
   localparam int TAG_W = 4;
   localparam int OUT_W = (IN_W / GRP) * (GRP + 2);

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [IN_W-1:0]  in_data = '0;
   logic [OUT_W-1:0] in_key = '0;
   logic             in_mode = 1'b0;
   logic [TAG_W-1:0] in_tag = '0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [OUT_W-1:0] out_data;
   logic [TAG_W-1:0] out_tag;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct packed {
      logic [OUT_W-1:0] d;
      logic [TAG_W-1:0] t;
   } word_t;

   word_t q[$];

   expansion_mix_pipe #(
      .IN_W(IN_W), .GRP(GRP), .PIPE(PIPE), .TAG_W(TAG_W)
   ) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_key(in_key),
      .in_mode(in_mode), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_tag(out_tag)
   );

   always #5 clk = ~clk;

   // Output bit o belongs to group o/(GRP+2), position o%(GRP+2); it copies
   // input bit (group*GRP + position - 1) modulo IN_W.
   function automatic logic [OUT_W-1:0] ref_mix(input logic [IN_W-1:0] d,
                                                input logic [OUT_W-1:0] k,
                                                input logic m);
      logic [OUT_W-1:0] e;
      int src;
      e = '0;
      for (int o = 0; o < OUT_W; o++) begin
         src  = ((o / (GRP + 2)) * GRP + (o % (GRP + 2)) - 1 + IN_W) % IN_W;
         e[o] = d[src];
      end
      return m ? e : (e ^ k);
   endfunction

   task automatic chk(input string nm, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", nm, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Send one word with out_ready high; check latency and result
   task automatic send_one(input string nm, input logic [IN_W-1:0] d,
                           input logic [OUT_W-1:0] k, input logic m,
                           input logic [TAG_W-1:0] t,
                           input logic [OUT_W-1:0] exp);
      int cyc;
      out_ready = 1'b1;
      in_data   = d;
      in_key    = k;
      in_mode   = m;
      in_tag    = t;
      in_valid  = 1'b1;
      #1;
      chk({nm, "_rdy"}, 64'(in_ready), 64'(1));
      step();
      in_valid = 1'b0;
      cyc = 1;
      while (!out_valid && cyc < 20) begin
         step();
         cyc++;
      end
      chk({nm, "_lat"}, 64'(cyc), 64'(PIPE));
      chk({nm, "_dat"}, 64'(out_data), 64'(exp));
      chk({nm, "_mdl"}, 64'(out_data), 64'(ref_mix(d, k, m)));
      chk({nm, "_tag"}, 64'(out_tag), 64'(t));
      step();
      chk({nm, "_gone"}, 64'(out_valid), 64'(0));
   endtask

   initial begin
      logic [IN_W-1:0]  d1, d2, d3;
      logic [OUT_W-1:0] k1, k2, k3;
      logic             fin, fout;
      int               cyc;

      // Reset state
      #1;
      chk("rst_ovalid", 64'(out_valid), 64'(0));
      chk("rst_irdy",   64'(in_ready),  64'(1));
      chk("rst_odata",  64'(out_data),  64'(0));
      chk("rst_otag",   64'(out_tag),   64'(0));
      step();
      rst = 1'b0;
      step();

      // Expansion wraps and key mixing
      send_one("wrap0", 32'h0000_0001, '0, 1'b1, 4'd3, 48'h8000_0000_0002);
      send_one("wrap31", 32'h8000_0000, '0, 1'b1, 4'd5, 48'h4000_0000_0001);
      send_one("ones", 32'hFFFF_FFFF, 48'h1234_5678_9ABC, 1'b1, 4'd6,
               48'hFFFF_FFFF_FFFF);
      send_one("key0", 32'h0000_0001, 48'hFFFF_FFFF_FFFF, 1'b0, 4'd7,
               48'h7FFF_FFFF_FFFD);
      send_one("key1", 32'h0000_0001, 48'hFFFF_FFFF_FFFF, 1'b1, 4'd8,
               48'h8000_0000_0002);

      // Backpressure: two held, third refused until downstream drains
      d1 = $urandom; d2 = $urandom; d3 = $urandom;
      k1 = {16'($urandom), 32'($urandom)};
      k2 = {16'($urandom), 32'($urandom)};
      k3 = {16'($urandom), 32'($urandom)};
      out_ready = 1'b0;
      in_mode = 1'b0;
      in_valid = 1'b1; in_data = d1; in_key = k1; in_tag = 4'd1;
      #1;
      chk("bp_rdy1", 64'(in_ready), 64'(1));
      step();
      in_data = d2; in_key = k2; in_tag = 4'd2;
      #1;
      chk("bp_rdy2", 64'(in_ready), 64'(1));
      step();
      in_data = d3; in_key = k3; in_tag = 4'd3;
      #1;
      for (int i = 0; i < 3; i++) begin
         chk("bp_full_rdy", 64'(in_ready),  64'(0));
         chk("bp_hold_vld", 64'(out_valid), 64'(1));
         chk("bp_hold_tag", 64'(out_tag),   64'(1));
         chk("bp_hold_dat", 64'(out_data),  64'(ref_mix(d1, k1, 1'b0)));
         step();
      end
      out_ready = 1'b1;
      #1;
      chk("bp_rel_rdy", 64'(in_ready), 64'(1));
      chk("bp_out1_tag", 64'(out_tag), 64'(1));
      step();
      in_valid = 1'b0;
      chk("bp_out2_vld", 64'(out_valid), 64'(1));
      chk("bp_out2_tag", 64'(out_tag),   64'(2));
      chk("bp_out2_dat", 64'(out_data),  64'(ref_mix(d2, k2, 1'b0)));
      step();
      chk("bp_out3_vld", 64'(out_valid), 64'(1));
      chk("bp_out3_tag", 64'(out_tag),   64'(3));
      chk("bp_out3_dat", 64'(out_data),  64'(ref_mix(d3, k3, 1'b0)));
      step();
      chk("bp_empty", 64'(out_valid), 64'(0));

      // Streaming: word s driven at step s appears at step s+PIPE
      out_ready = 1'b1;
      q.delete();
      for (int s = 0; s < 8 + PIPE + 1; s++) begin
         if (s < 8) begin
            in_valid = 1'b1;
            in_data  = $urandom;
            in_key   = {16'($urandom), 32'($urandom)};
            in_mode  = 1'($urandom);
            in_tag   = 4'(s);
            q.push_back('{ref_mix(in_data, in_key, in_mode), 4'(s)});
         end else begin
            in_valid = 1'b0;
         end
         #1;
         if (s < 8) chk("st_rdy", 64'(in_ready), 64'(1));
         chk("st_vld", 64'(out_valid), 64'(s >= PIPE && s < 8 + PIPE));
         if (s >= PIPE && s < 8 + PIPE) begin
            chk("st_tag", 64'(out_tag),  64'(q[s-PIPE].t));
            chk("st_dat", 64'(out_data), 64'(q[s-PIPE].d));
         end
         step();
      end
      q.delete();

      // Reset with two words in flight
      out_ready = 1'b0;
      in_mode = 1'b1;
      in_valid = 1'b1; in_data = 32'hDEAD_BEEF; in_tag = 4'hA;
      step();
      in_data = 32'hCAFE_F00D; in_tag = 4'hB;
      step();
      in_valid = 1'b0;
      chk("rm_pre_vld", 64'(out_valid), 64'(1));
      rst = 1'b1;
      #1;
      chk("rm_vld", 64'(out_valid), 64'(0));
      chk("rm_dat", 64'(out_data),  64'(0));
      chk("rm_tag", 64'(out_tag),   64'(0));
      chk("rm_rdy", 64'(in_ready),  64'(1));
      #2;
      rst = 1'b0;
      step();
      send_one("rm_new", 32'h0000_0001, 48'h0000_0000_000F, 1'b0, 4'h2,
               48'h8000_0000_000D);
      for (int i = 0; i < 4; i++) begin
         chk("rm_no_old", 64'(out_valid), 64'(0));
         step();
      end

      // Randomized traffic against a FIFO scoreboard
      q.delete();
      for (int c = 0; c < 400; c++) begin
         in_valid  = 1'($urandom_range(0, 3) != 0);
         out_ready = 1'($urandom_range(0, 2) != 0);
         in_data   = $urandom;
         in_key    = {16'($urandom), 32'($urandom)};
         in_mode   = 1'($urandom);
         in_tag    = 4'($urandom);
         #1;
         chk("rnd_rdy", 64'(in_ready), 64'(q.size() < PIPE || out_ready));
         fin  = in_valid && in_ready;
         fout = out_valid && out_ready;
         if (fout) begin
            if (q.size() == 0) begin
               chk("rnd_spurious", 64'(out_valid), 64'(0));
            end else begin
               chk("rnd_tag", 64'(out_tag),  64'(q[0].t));
               chk("rnd_dat", 64'(out_data), 64'(q[0].d));
               void'(q.pop_front());
            end
         end
         if (fin) q.push_back('{ref_mix(in_data, in_key, in_mode), in_tag});
         step();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      cyc = 0;
      while (q.size() != 0 && cyc < 20) begin
         #1;
         if (out_valid) begin
            chk("drn_tag", 64'(out_tag),  64'(q[0].t));
            chk("drn_dat", 64'(out_data), 64'(q[0].d));
            void'(q.pop_front());
         end
         step();
         cyc++;
      end
      chk("drn_left", 64'(q.size()), 64'(0));
      #1;
      chk("drn_idle", 64'(out_valid), 64'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
